// File: rtl/systolic_array_ws.sv
// Weight-stationary ROWS x COLS systolic MAC array with weight-load handshake,
// input skew / output deskew, valid/ready flow control with global stall,
// control FSM, saturating op counter and sticky overflow flag.
// Optional build macro RELU_EN adds a runtime ReLU stage after the deskew.
module systolic_array_ws #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [WIDTH-1:0]        w_data,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [ROWS*WIDTH-1:0]   a_data,
    input  logic                    a_last,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [COLS*WIDTH-1:0]   o_data,
    input  logic                    relu_mode,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             int_ops,
    output logic                    overflow
);

    localparam int unsigned N_PE = ROWS * COLS;
    localparam int unsigned WCW  = $clog2(N_PE);
    localparam int unsigned LAT  = ROWS + COLS;
    localparam int unsigned SW   = 2 * WIDTH + 1;
    localparam logic signed [SW-1:0] SAT_MAX = SW'({1'b0, {(WIDTH-1){1'b1}}});
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_COMPUTE, S_DRAIN} state_t;

    state_t                   state, state_nxt;
    logic                     stall, adv, w_fire, a_fire, w_last, drain_empty;
    logic [WCW-1:0]           w_cnt;
    logic signed [WIDTH-1:0]  w_mem   [N_PE];
    logic [LAT-1:0]           vld;
    logic signed [WIDTH-1:0]  a_row   [ROWS];
    logic signed [WIDTH-1:0]  a_reg   [ROWS][COLS-1];
    logic signed [WIDTH-1:0]  p_reg   [ROWS][COLS];
    logic [N_PE-1:0]          sat_vec;
    logic signed [WIDTH-1:0]  col_out [COLS];
    logic signed [WIDTH-1:0]  col_val [COLS];
    logic [32:0]              ops_sum;

    assign stall       = o_valid && !o_ready;
    assign adv         = !stall;
    assign w_fire      = w_valid && w_ready;
    assign a_fire      = a_valid && a_ready;
    assign w_last      = (w_cnt == WCW'(N_PE - 1));
    assign drain_empty = (vld == '0) && !stall;
    assign ops_sum     = 33'(int_ops) + 33'(N_PE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (w_fire) state_nxt = S_LOAD_W;
            S_LOAD_W:  if (w_fire && w_last) state_nxt = S_COMPUTE;
            S_COMPUTE: if (a_fire && a_last) state_nxt = S_DRAIN;
            S_DRAIN:   if (drain_empty) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // FSM-decoded handshake and status outputs
    always_comb begin
        w_ready = 1'b0;
        a_ready = 1'b0;
        busy    = 1'b0;
        case (state)
            S_IDLE:    w_ready = 1'b1;
            S_LOAD_W:  begin w_ready = 1'b1; busy = 1'b1; end
            S_COMPUTE: begin a_ready = !stall; busy = 1'b1; end
            S_DRAIN:   busy = 1'b1;
            default:   busy = 1'b0;
        endcase
    end

    // Done pulse coincides with the DRAIN -> IDLE transition
    always_ff @(posedge clk) begin
        if (!rst) done <= 1'b0;
        else      done <= (state == S_DRAIN) && drain_empty;
    end

    // Weight storage, row-major word counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_cnt <= '0;
            for (int k = 0; k < int'(N_PE); k++) w_mem[k] <= '0;
        end else if (w_fire) begin
            w_mem[w_cnt] <= w_data;
            w_cnt        <= w_last ? '0 : w_cnt + WCW'(1);
        end
    end

    // Input skew: row i delayed i cycles behind row 0, idle slots carry zero
    for (genvar i = 0; i < ROWS; i++) begin : g_skew
        logic signed [WIDTH-1:0] sq [i+1];
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int k = 0; k <= i; k++) sq[k] <= '0;
            end else if (adv) begin
                sq[0] <= a_fire ? a_data[i*WIDTH +: WIDTH] : '0;
                for (int k = 1; k <= i; k++) sq[k] <= sq[k-1];
            end
        end
        assign a_row[i] = sq[i];
    end

    // PE grid: activations move right, saturated partial sums move down
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_pe
            logic signed [WIDTH-1:0]   act, psum_in, psum_nxt, psum_q;
            logic signed [2*WIDTH-1:0] prod;
            logic signed [SW-1:0]      full;
            logic                      sat;

            if (j == 0) begin : g_al
                assign act = a_row[i];
            end else begin : g_ar
                assign act = a_reg[i][j-1];
            end

            if (i == 0) begin : g_pt
                assign psum_in = '0;
            end else begin : g_pi
                assign psum_in = p_reg[i-1][j];
            end

            assign prod = (2*WIDTH)'(act) * (2*WIDTH)'(w_mem[i*COLS+j]);
            assign full = SW'(prod) + SW'(psum_in);

            // Clamp to the signed WIDTH range and flag clipping
            always_comb begin
                sat      = 1'b0;
                psum_nxt = full[WIDTH-1:0];
                if (full > SAT_MAX) begin
                    sat      = 1'b1;
                    psum_nxt = {1'b0, {(WIDTH-1){1'b1}}};
                end else if (full < SAT_MIN) begin
                    sat      = 1'b1;
                    psum_nxt = {1'b1, {(WIDTH-1){1'b0}}};
                end
            end

            // Partial-sum register
            always_ff @(posedge clk) begin
                if (!rst)     psum_q <= '0;
                else if (adv) psum_q <= psum_nxt;
            end

            assign p_reg[i][j]          = psum_q;
            assign sat_vec[i*COLS + j]  = sat;

            if (j < COLS - 1) begin : g_fwd
                logic signed [WIDTH-1:0] act_q;
                // Activation forward register
                always_ff @(posedge clk) begin
                    if (!rst)     act_q <= '0;
                    else if (adv) act_q <= act;
                end
                assign a_reg[i][j] = act_q;
            end
        end
    end

    // Output deskew: column j delayed COLS-1-j cycles to realign the vector
    for (genvar j = 0; j < COLS; j++) begin : g_dsk
        localparam int unsigned D = COLS - 1 - j;
        if (D == 0) begin : g_direct
            assign col_out[j] = p_reg[ROWS-1][j];
        end else begin : g_dly
            logic signed [WIDTH-1:0] dq [D];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < int'(D); k++) dq[k] <= '0;
                end else if (adv) begin
                    dq[0] <= p_reg[ROWS-1][j];
                    for (int k = 1; k < int'(D); k++) dq[k] <= dq[k-1];
                end
            end
            assign col_out[j] = dq[D-1];
        end
    end

`ifdef RELU_EN
    // Runtime ReLU on the aligned vector
    always_comb begin
        for (int j = 0; j < int'(COLS); j++) begin
            col_val[j] = col_out[j];
            if (relu_mode && col_out[j][WIDTH-1]) col_val[j] = '0;
        end
    end
`else
    logic unused_relu;
    assign unused_relu = relu_mode;

    // Raw saturated sums pass straight through
    always_comb begin
        for (int j = 0; j < int'(COLS); j++) col_val[j] = col_out[j];
    end
`endif

    // Valid tracking and output register, frozen while stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (adv) begin
            vld     <= {vld[LAT-2:0], a_fire};
            o_valid <= vld[LAT-1];
            for (int j = 0; j < int'(COLS); j++) o_data[j*WIDTH +: WIDTH] <= col_val[j];
        end
    end

    // Op counter and sticky overflow, both cleared by a new weight load
    always_ff @(posedge clk) begin
        if (!rst) begin
            int_ops  <= '0;
            overflow <= 1'b0;
        end else if ((state == S_IDLE) && w_fire) begin
            int_ops  <= '0;
            overflow <= 1'b0;
        end else begin
            if (a_fire)            int_ops  <= ops_sum[32] ? '1 : ops_sum[31:0];
            if (adv && |sat_vec)   overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed bench for systolic_array_ws (4x4, 16-bit): vector table plus
// hand sequences for reset, streaming with backpressure and mid-run reset.
module tb_systolic_array_ws;

    logic        clk, rst;
    logic        w_valid, w_ready;
    logic [15:0] w_data;
    logic        a_valid, a_ready, a_last;
    logic [63:0] a_data;
    logic        o_valid, o_ready;
    logic [63:0] o_data;
    logic        relu_mode, busy, done, overflow;
    logic [31:0] int_ops;

    systolic_array_ws #(.WIDTH(16), .ROWS(4), .COLS(4)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .relu_mode(relu_mode), .busy(busy), .done(done),
        .int_ops(int_ops), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = diagonal wv, 1 = all wv, 2 = row0 (1,2,3,4)
    typedef struct {
        int          kind;
        logic [15:0] wv;
        logic [63:0] a;
        logic        relu;
        logic [63:0] y;
        logic        ovf;
    } vec_t;

    vec_t tbl [7];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_w(input int kind, input logic [15:0] v);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            w_valid = 1'b1;
            case (kind)
                0:       w_data = ((k / 4) == (k % 4)) ? v : 16'h0;
                1:       w_data = v;
                default: w_data = (k < 4) ? 16'(k + 1) : 16'h0;
            endcase
            @(posedge clk);
        end
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        load_w(v.kind, v.wv);
        chk({tag, " w_ready"}, 64'(w_ready), 64'd0);
        chk({tag, " a_ready"}, 64'(a_ready), 64'd1);
        relu_mode = v.relu;
        o_ready   = 1'b1;
        a_valid   = 1'b1;
        a_data    = v.a;
        a_last    = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        a_last  = 1'b0;
        cyc = 0;
        while (!o_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"},  64'(cyc), 64'd8);
        chk({tag, " o_data"},   o_data, v.y);
        chk({tag, " overflow"}, 64'(overflow), 64'(v.ovf));
        chk({tag, " int_ops"},  64'(int_ops), 64'd16);
        @(negedge clk);
        chk({tag, " done"},     64'(done), 64'd1);
        chk({tag, " busy"},     64'(busy), 64'd0);
        chk({tag, " o_valid"},  64'(o_valid), 64'd0);
        @(negedge clk);
        chk({tag, " done_end"}, 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t zv;
        int   nsent, nres, seen;
        logic [15:0] r;

        tbl[0] = '{0, 16'h0001, 64'h0004_0003_0002_0001, 1'b0, 64'h0004_0003_0002_0001, 1'b0};
        tbl[1] = '{1, 16'h0001, 64'h0003_0007_FFEC_0064, 1'b0, 64'h005A_005A_005A_005A, 1'b0};
        tbl[2] = '{1, 16'h7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 1'b0, 64'h7FFF_7FFF_7FFF_7FFF, 1'b1};
        tbl[3] = '{0, 16'h0001, 64'hFFF8_0007_FFFA_0005, 1'b0, 64'hFFF8_0007_FFFA_0005, 1'b0};
        tbl[4] = '{1, 16'h7FFF, 64'h8000_8000_8000_8000, 1'b0, 64'h8000_8000_8000_8000, 1'b1};
        tbl[5] = '{0, 16'hFFFF, 64'h0004_0003_0002_0001, 1'b0, 64'hFFFC_FFFD_FFFE_FFFF, 1'b0};
`ifdef RELU_EN
        tbl[6] = '{0, 16'hFFFF, 64'h0004_0003_0002_0001, 1'b1, 64'h0000_0000_0000_0000, 1'b0};
`else
        tbl[6] = '{0, 16'hFFFF, 64'h0004_0003_0002_0001, 1'b1, 64'hFFFC_FFFD_FFFE_FFFF, 1'b0};
`endif

        rst = 1'b0; w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
        a_last = 1'b0; o_ready = 1'b1; relu_mode = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst o_valid",  64'(o_valid), 64'd0);
        chk("rst o_data",   o_data, 64'd0);
        chk("rst int_ops",  64'(int_ops), 64'd0);
        chk("rst overflow", 64'(overflow), 64'd0);
        chk("rst w_ready",  64'(w_ready), 64'd1);
        chk("rst a_ready",  64'(a_ready), 64'd0);
        chk("rst busy",     64'(busy), 64'd0);
        chk("rst done",     64'(done), 64'd0);
        rst = 1'b1;

        // Single-vector table
        for (int n = 0; n < 7; n++) run_vec(tbl[n], $sformatf("vec%0d", n));

        // Stream of 10 vectors with o_ready low during loop cycles 9..11
        relu_mode = 1'b0;
        load_w(2, 16'h0);
        nsent = 0;
        nres  = 0;
        for (int c = 0; c < 80 && nres < 10; c++) begin
            if (c > 0) @(negedge clk);
            o_ready = !(c >= 9 && c <= 11);
            if (nsent < 10) begin
                a_valid = 1'b1;
                a_data  = {48'h0, 16'(nsent + 1)};
                a_last  = (nsent == 9);
            end else begin
                a_valid = 1'b0;
                a_last  = 1'b0;
            end
            #1;
            r = 16'(nres + 1);
            if (o_valid) begin
                if (o_ready) begin
                    chk($sformatf("stream y%0d", nres + 1), o_data,
                        {16'(4 * r), 16'(3 * r), 16'(2 * r), r});
                    nres++;
                end else begin
                    chk($sformatf("stall a_ready c%0d", c), 64'(a_ready), 64'd0);
                    chk($sformatf("stall hold c%0d", c), o_data,
                        {16'(4 * r), 16'(3 * r), 16'(2 * r), r});
                end
            end
            if (a_valid && a_ready) nsent++;
        end
        chk("stream count", 64'(nres), 64'd10);
        @(negedge clk);
        a_valid = 1'b0;
        a_last  = 1'b0;
        chk("stream done",    64'(done), 64'd1);
        chk("stream busy",    64'(busy), 64'd0);
        chk("stream int_ops", 64'(int_ops), 64'd160);

        // Reset with three results in flight
        load_w(0, 16'h0001);
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1;
            a_data  = {16'(k + 4), 16'(k + 3), 16'(k + 2), 16'(k + 1)};
            @(negedge clk);
        end
        a_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst busy",    64'(busy), 64'd0);
        chk("midrst w_ready", 64'(w_ready), 64'd1);
        chk("midrst a_ready", 64'(a_ready), 64'd0);
        chk("midrst int_ops", 64'(int_ops), 64'd0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        chk("midrst no o_valid", 64'(seen), 64'd0);
        zv = '{1, 16'h0000, 64'h0004_0003_0002_0001, 1'b0, 64'h0, 1'b0};
        run_vec(zv, "zero_w");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_array_ws.md
Name: systolic_array_ws

Overview:
Parametrised weight-stationary systolic array of ROWS x COLS MAC processing elements, the successor of the fixed 4x4 PE matrix. It adds a weight-load handshake, internal input skew and output deskew, valid/ready flow control with a global stall, a control FSM, a saturating op counter and a sticky overflow flag. It sits between the activation buffer and the output/activation stage of the NPU datapath.

Parameters:
WIDTH, 16, signed data/weight/partial-sum width
ROWS, 4, PE rows (input vector length), >=2
COLS, 4, PE columns (output vector length), >=2

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
w_valid  input  1  weight word valid
w_ready  output  1  weight word accepted when w_valid&&w_ready
w_data  input  WIDTH  weight word, row-major order W[0][0], W[0][1] .. W[ROWS-1][COLS-1]
a_valid  input  1  activation vector valid
a_ready  output  1  activation vector accepted when a_valid&&a_ready
a_data  input  ROWS*WIDTH  a[i] at bits [i*WIDTH +: WIDTH]
a_last  input  1  marks last vector of a batch, sampled on acceptance
o_valid  output  1  result vector valid
o_ready  input  1  downstream accepts result
o_data  output  COLS*WIDTH  y[j] at bits [j*WIDTH +: WIDTH]
relu_mode  input  1  runtime ReLU select (see Optional Feature)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when DRAIN completes
int_ops  output  32  MAC count since last weight load
overflow  output  1  sticky saturation flag

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; all PE registers, weights, skew/deskew buffers zeroed; w_ready=1, a_ready=0, o_valid=0, o_data=0, busy=0, done=0, int_ops=0, overflow=0. Reset mid-operation aborts; in-flight results are discarded, never emitted.
- Function: y[j] = sum over i of a[i]*W[i][j]. Each PE: product 2*WIDTH bits, added to incoming partial sum, saturated to signed WIDTH (max 2^(WIDTH-1)-1, min -2^(WIDTH-1)); any saturation sets overflow.
- Dataflow: activations move right one PE per cycle, partial sums move down one PE per cycle; row i input delayed i cycles (skew), column j output delayed COLS-1-j cycles (deskew), so o_data is one aligned vector.
- Latency: a vector accepted at edge t presents o_valid at edge t+ROWS+COLS when no stall occurs. Back-to-back vectors give one result per cycle; results emerge in acceptance order.
- Stall: when o_valid && !o_ready, the entire pipeline (PEs, skew, deskew, counters) holds; a_ready=0; o_data stable.
- FSM:
  - IDLE: w_ready=1. First accepted weight word -> LOAD_W; it is stored as W[0][0]. int_ops and overflow are cleared on that word.
  - LOAD_W: w_ready=1, word counter 0..ROWS*COLS-1. Accepting the last word -> COMPUTE.
  - COMPUTE: w_ready=0, a_ready=!stall. Accepting a vector with a_last=1 -> DRAIN.
  - DRAIN: a_ready=0. Stay until every in-flight result has been accepted downstream, then -> IDLE with done=1 for one cycle.
- Weights remain valid in IDLE; reloading is the only way to change them.
- int_ops: +ROWS*COLS per accepted activation vector; saturates at 2^32-1, no wrap.
- overflow: sticky until rst or the next weight load.
- Simultaneous events: acceptance of the final result and the DRAIN exit share a cycle. An accepted vector carrying a_last=1 is itself computed and emitted.

Optional Feature:
Macro RELU_EN.
- Defined: a ReLU stage after deskew, zero added latency. When relu_mode=1, negative y[j] -> 0; when relu_mode=0, values pass through.
- Undefined: no ReLU logic is built and relu_mode is ignored; o_data is always the raw saturated sum.

Test Plan (ROWS=COLS=4, WIDTH=16):
- Reset: hold rst=0 2 cycles -> o_valid=0, o_data=0, int_ops=0, overflow=0, w_ready=1, a_ready=0, busy=0.
- Identity: load W[i][i]=1, others 0; send a=(1,2,3,4) with a_last=1 at edge t, o_ready=1 -> o_valid at t+8, y=(1,2,3,4), int_ops=16, done pulses after acceptance.
- General and saturation: W all 1, a=(100,-20,7,3) -> y[j]=90 for all j, overflow=0. Then reload W all 0x7FFF and send a=(0x7FFF,..) -> y[j]=0x7FFF, overflow=1.
- Stream and backpressure: 10 back-to-back vectors with a[0]=k (k=1..10), W[0][j]=j+1; drop o_ready for 3 cycles mid-stream -> o_data held, a_ready=0, all 10 results in order with y[j]=k*(j+1), int_ops=160.
- Reset mid-COMPUTE: pull rst=0 with 3 results in flight -> no o_valid afterwards, state IDLE, weights zero (next a yields 0 after a zero-weight load).
- RELU_EN: W[i][i]=-1, a=(1,2,3,4) -> relu_mode=0 gives y=(-1,-2,-3,-4); relu_mode=1 gives y=(0,0,0,0). With the macro undefined, both modes give (-1,-2,-3,-4).
